nfc_atom_cmd_addr: RTL

Pin-pattern generator ("atom") for the NAND flash controller. It emits one command byte followed by 0-5 address bytes on the 4-phase-per-clock PHY bus, then a programmable post-wait, and signals completion. The way sequencer runs it before handing the PHY bus back to the idle atom. Its outputs feed the same PHY output mux as the idle atom and use the identical bus format, so the mux can switch between the two atoms on any clock edge.

---
 rtl/nfc_atom_cmd_addr.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/nfc_atom_cmd_addr.sv
`default_nettype none
// ============================================================================
// Module   : nfc_atom_cmd_addr
// Purpose  : NAND command/address pin-pattern atom. Emits one command byte,
//            0-5 address bytes and a programmable post-wait on the 4-phase
//            PHY bus, then pulses oLastStep.
// Revision : 1.0 - initial release
// ============================================================================
module nfc_atom_cmd_addr #(
  parameter int NumberOfWays = 4
) (
  input  logic                        iSystemClock,
  input  logic                        iReset,
  input  logic                        iStart,
  output logic                        oReady,
  output logic                        oLastStep,
  input  logic [7:0]                  iCommand,
  input  logic [39:0]                 iAddress,
  input  logic [2:0]                  iAddressCount,
  input  logic [7:0]                  iPostWait,
  input  logic [NumberOfWays-1:0]     iTargetWay,
  output logic                        oDQSOutEnable,
  output logic                        oDQOutEnable,
  output logic [7:0]                  oDQStrobe,
  output logic [31:0]                 oDQ,
  output logic [2*NumberOfWays-1:0]   oChipEnable,
  output logic [3:0]                  oReadEnable,
  output logic [3:0]                  oWriteEnable,
  output logic [3:0]                  oAddressLatchEnable,
  output logic [3:0]                  oCommandLatchEnable
);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_CMD_SETUP   = 4'd1,
    S_CMD_STROBE  = 4'd2,
    S_CMD_HOLD    = 4'd3,
    S_ADDR_SETUP  = 4'd4,
    S_ADDR_STROBE = 4'd5,
    S_ADDR_HOLD   = 4'd6,
    S_POST_WAIT   = 4'd7,
    S_DONE        = 4'd8
  } state_t;

  localparam logic [3:0] c_WE_HIGH   = 4'b1111;
  localparam logic [3:0] c_WE_STROBE = 4'b1100;
  localparam logic [3:0] c_RE_IDLE   = 4'b0011;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [7:0]                r_cmd;
  logic [39:0]               r_addr;
  logic [2:0]                r_count;
  logic [7:0]                r_postwait;
  logic [NumberOfWays-1:0]   r_way;
  logic [2:0]                r_idx;
  logic [7:0]                r_wait_cnt;

  logic [2:0]                w_count_clamped;
  logic                      w_last_addr;
  logic                      w_enter_wait;
  logic [7:0]                w_addr_byte;
  logic [7:0]                w_byte;

  // Counts of 6 and 7 are not meaningful for NAND addressing; treat as 5.
  assign w_count_clamped = (iAddressCount > 3'd5) ? 3'd5 : iAddressCount;
  assign w_last_addr     = (r_idx == (r_count - 3'd1));
  assign w_enter_wait    = ((r_state == S_CMD_HOLD) && (r_count == 3'd0)) ||
                           ((r_state == S_ADDR_HOLD) && w_last_addr);
  assign oChipEnable     = {r_way, r_way};
  assign oDQ             = {4{w_byte}};

  // Address byte currently being transferred, byte 0 first.
  always_comb begin
    w_addr_byte = 8'h00;
    case (r_idx)
      3'd0:    w_addr_byte = r_addr[7:0];
      3'd1:    w_addr_byte = r_addr[15:8];
      3'd2:    w_addr_byte = r_addr[23:16];
      3'd3:    w_addr_byte = r_addr[31:24];
      3'd4:    w_addr_byte = r_addr[39:32];
      default: w_addr_byte = 8'h00;
    endcase
  end

  // State register; reset returns to IDLE from anywhere, even mid-sequence.
  always_ff @(posedge iSystemClock) begin
    if (!iReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latches, address byte index and post-wait down-counter.
  always_ff @(posedge iSystemClock) begin
    if (!iReset) begin
      r_cmd      <= 8'h00;
      r_addr     <= 40'h0;
      r_count    <= 3'd0;
      r_postwait <= 8'h00;
      r_way      <= '0;
      r_idx      <= 3'd0;
      r_wait_cnt <= 8'h00;
    end else begin
      if ((r_state == S_IDLE) && iStart) begin
        r_cmd      <= iCommand;
        r_addr     <= iAddress;
        r_count    <= w_count_clamped;
        r_postwait <= iPostWait;
        r_way      <= iTargetWay;
        r_idx      <= 3'd0;
      end
      if (r_state == S_ADDR_HOLD) begin
        r_idx <= w_last_addr ? 3'd0 : (r_idx + 3'd1);
      end
      if (w_enter_wait) begin
        r_wait_cnt <= r_postwait;
      end else if ((r_state == S_POST_WAIT) && (r_wait_cnt != 8'h00)) begin
        r_wait_cnt <= r_wait_cnt - 8'd1;
      end
    end
  end

  // Next-state decode and per-state pin patterns; idle pattern is the default.
  always_comb begin
    w_next_state        = r_state;
    oReady              = 1'b0;
    oLastStep           = 1'b0;
    oDQSOutEnable       = 1'b1;
    oDQOutEnable        = 1'b1;
    oDQStrobe           = 8'h00;
    oReadEnable         = c_RE_IDLE;
    oWriteEnable        = c_WE_HIGH;
    oAddressLatchEnable = 4'h0;
    oCommandLatchEnable = 4'h0;
    w_byte              = 8'h00;

    case (r_state)
      S_IDLE: begin
        oReady = 1'b1;
        if (iStart) begin
          w_next_state = S_CMD_SETUP;
        end
      end
      S_CMD_SETUP: begin
        w_byte              = r_cmd;
        oCommandLatchEnable = 4'hF;
        w_next_state        = S_CMD_STROBE;
      end
      S_CMD_STROBE: begin
        w_byte              = r_cmd;
        oCommandLatchEnable = 4'hF;
        oWriteEnable        = c_WE_STROBE;
        w_next_state        = S_CMD_HOLD;
      end
      S_CMD_HOLD: begin
        w_byte              = r_cmd;
        oCommandLatchEnable = 4'hF;
        w_next_state        = (r_count != 3'd0) ? S_ADDR_SETUP : S_POST_WAIT;
      end
      S_ADDR_SETUP: begin
        w_byte              = w_addr_byte;
        oAddressLatchEnable = 4'hF;
        w_next_state        = S_ADDR_STROBE;
      end
      S_ADDR_STROBE: begin
        w_byte              = w_addr_byte;
        oAddressLatchEnable = 4'hF;
        oWriteEnable        = c_WE_STROBE;
        w_next_state        = S_ADDR_HOLD;
      end
      S_ADDR_HOLD: begin
        w_byte              = w_addr_byte;
        oAddressLatchEnable = 4'hF;
        w_next_state        = w_last_addr ? S_POST_WAIT : S_ADDR_SETUP;
      end
      S_POST_WAIT: begin
        // A loaded value of 0 or 1 both leave after a single clock.
        if (r_wait_cnt <= 8'd1) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        oLastStep    = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
